// File: rtl/id_ex_fwd_reg_if.sv
// ID/EX boundary bundle: ID-stage fields in, registered EX fields and
// hazard/forwarding controls out. The slave side is the pipeline register.
interface id_ex_fwd_reg_if #(
  parameter int XLEN = 32
);
  logic            i_id_valid;
  logic [4:0]      i_id_rs1_addr;
  logic [4:0]      i_id_rs2_addr;
  logic [4:0]      i_id_rd_addr;
  logic [XLEN-1:0] i_id_rs1_data;
  logic [XLEN-1:0] i_id_rs2_data;
  logic [XLEN-1:0] i_id_imm;
  logic [XLEN-1:0] i_id_pc;
  logic            i_id_rd_wren;
  logic            i_id_is_load;
  logic            i_flush;
  logic [4:0]      i_exmem_rd_addr;
  logic [4:0]      i_memwb_rd_addr;
  logic            i_exmem_rd_wren;
  logic            i_memwb_rd_wren;

  logic            o_ex_valid;
  logic            o_ex_rd_wren;
  logic            o_ex_is_load;
  logic [4:0]      o_ex_rs1_addr;
  logic [4:0]      o_ex_rs2_addr;
  logic [4:0]      o_ex_rd_addr;
  logic [XLEN-1:0] o_ex_rs1_data;
  logic [XLEN-1:0] o_ex_rs2_data;
  logic [XLEN-1:0] o_ex_imm;
  logic [XLEN-1:0] o_ex_pc;
  logic [1:0]      o_fwd_a_sel;
  logic [1:0]      o_fwd_b_sel;
  logic            o_stall;

  modport slave (
    input  i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr,
           i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_pc,
           i_id_rd_wren, i_id_is_load, i_flush,
           i_exmem_rd_addr, i_memwb_rd_addr, i_exmem_rd_wren, i_memwb_rd_wren,
    output o_ex_valid, o_ex_rd_wren, o_ex_is_load,
           o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd_addr,
           o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_pc,
           o_fwd_a_sel, o_fwd_b_sel, o_stall
  );

  modport master (
    output i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr,
           i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_pc,
           i_id_rd_wren, i_id_is_load, i_flush,
           i_exmem_rd_addr, i_memwb_rd_addr, i_exmem_rd_wren, i_memwb_rd_wren,
    input  o_ex_valid, o_ex_rd_wren, o_ex_is_load,
           o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd_addr,
           o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_pc,
           o_fwd_a_sel, o_fwd_b_sel, o_stall
  );
endinterface

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with load-use stall detection and EX operand
// forwarding selects. A stall only injects a bubble here; the ID stage
// re-presents the same instruction, which is captured on the next edge.
module id_ex_fwd_reg #(
  parameter int XLEN = 32
) (
  input logic           i_clk,
  input logic           i_reset,
  id_ex_fwd_reg_if.slave bus
);

  logic            ex_valid_q, ex_valid_d;
  logic            ex_rd_wren_q, ex_rd_wren_d;
  logic            ex_is_load_q, ex_is_load_d;
  logic [4:0]      ex_rs1_addr_q, ex_rs1_addr_d;
  logic [4:0]      ex_rs2_addr_q, ex_rs2_addr_d;
  logic [4:0]      ex_rd_addr_q, ex_rd_addr_d;
  logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;

  logic       stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic       ex_valid,
    input logic [4:0] rs,
    input logic       exmem_wren,
    input logic [4:0] exmem_rd,
    input logic       memwb_wren,
    input logic [4:0] memwb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_valid) begin
      if (exmem_wren && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
        sel = 2'b01;
      end else if (memwb_wren && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  // Load-use hazard: the EX load's result is not ready for the ID consumer.
  // A flush kills the consumer, so no stall is needed in that case.
  always_comb begin
    stall = ex_valid_q && ex_is_load_q && (ex_rd_addr_q != 5'd0) &&
            bus.i_id_valid &&
            ((ex_rd_addr_q == bus.i_id_rs1_addr) ||
             (ex_rd_addr_q == bus.i_id_rs2_addr)) &&
            !bus.i_flush;
  end

  // Forwarding selects for the two EX operand muxes.
  always_comb begin
    fwd_a_sel = fwd_sel(ex_valid_q, ex_rs1_addr_q,
                        bus.i_exmem_rd_wren, bus.i_exmem_rd_addr,
                        bus.i_memwb_rd_wren, bus.i_memwb_rd_addr);
    fwd_b_sel = fwd_sel(ex_valid_q, ex_rs2_addr_q,
                        bus.i_exmem_rd_wren, bus.i_exmem_rd_addr,
                        bus.i_memwb_rd_wren, bus.i_memwb_rd_addr);
  end

  // Next EX contents: normal capture, or a fully zeroed bubble on flush/stall.
  always_comb begin
    ex_valid_d    = bus.i_id_valid;
    ex_rd_wren_d  = bus.i_id_valid & bus.i_id_rd_wren;
    ex_is_load_d  = bus.i_id_valid & bus.i_id_is_load;
    ex_rs1_addr_d = bus.i_id_rs1_addr;
    ex_rs2_addr_d = bus.i_id_rs2_addr;
    ex_rd_addr_d  = bus.i_id_rd_addr;
    ex_rs1_data_d = bus.i_id_rs1_data;
    ex_rs2_data_d = bus.i_id_rs2_data;
    ex_imm_d      = bus.i_id_imm;
    ex_pc_d       = bus.i_id_pc;
    if (bus.i_flush || stall) begin
      ex_valid_d    = 1'b0;
      ex_rd_wren_d  = 1'b0;
      ex_is_load_d  = 1'b0;
      ex_rs1_addr_d = 5'd0;
      ex_rs2_addr_d = 5'd0;
      ex_rd_addr_d  = 5'd0;
      ex_rs1_data_d = '0;
      ex_rs2_data_d = '0;
      ex_imm_d      = '0;
      ex_pc_d       = '0;
    end
  end

  // EX register; reset wins over flush and stall, discarding any pending bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_valid_q    <= 1'b0;
      ex_rd_wren_q  <= 1'b0;
      ex_is_load_q  <= 1'b0;
      ex_rs1_addr_q <= 5'd0;
      ex_rs2_addr_q <= 5'd0;
      ex_rd_addr_q  <= 5'd0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_pc_q       <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rd_wren_q  <= ex_rd_wren_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_rs1_addr_q <= ex_rs1_addr_d;
      ex_rs2_addr_q <= ex_rs2_addr_d;
      ex_rd_addr_q  <= ex_rd_addr_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_pc_q       <= ex_pc_d;
    end
  end

  assign bus.o_ex_valid    = ex_valid_q;
  assign bus.o_ex_rd_wren  = ex_rd_wren_q;
  assign bus.o_ex_is_load  = ex_is_load_q;
  assign bus.o_ex_rs1_addr = ex_rs1_addr_q;
  assign bus.o_ex_rs2_addr = ex_rs2_addr_q;
  assign bus.o_ex_rd_addr  = ex_rd_addr_q;
  assign bus.o_ex_rs1_data = ex_rs1_data_q;
  assign bus.o_ex_rs2_data = ex_rs2_data_q;
  assign bus.o_ex_imm      = ex_imm_q;
  assign bus.o_ex_pc       = ex_pc_q;
  assign bus.o_fwd_a_sel   = fwd_a_sel;
  assign bus.o_fwd_b_sel   = fwd_b_sel;
  assign bus.o_stall       = stall;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Bench for id_ex_fwd_reg: expected EX register contents are pushed to a
// scoreboard queue at each edge and popped/compared after the edge.
module tb_id_ex_fwd_reg;

  typedef struct packed {
    logic        valid;
    logic        rd_wren;
    logic        is_load;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_t;

  logic i_clk;
  logic i_reset;

  id_ex_fwd_reg_if #(.XLEN(32)) bus ();

  id_ex_fwd_reg #(.XLEN(32)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  int   total = 0;
  int   bad   = 0;
  ex_t  m;
  ex_t  exp_q[$];
  ex_t  exp;
  ex_t  got;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic ex_t dut_ex();
    ex_t e;
    e.valid    = bus.o_ex_valid;
    e.rd_wren  = bus.o_ex_rd_wren;
    e.is_load  = bus.o_ex_is_load;
    e.rs1      = bus.o_ex_rs1_addr;
    e.rs2      = bus.o_ex_rs2_addr;
    e.rd       = bus.o_ex_rd_addr;
    e.rs1_data = bus.o_ex_rs1_data;
    e.rs2_data = bus.o_ex_rs2_data;
    e.imm      = bus.o_ex_imm;
    e.pc       = bus.o_ex_pc;
    return e;
  endfunction

  function automatic logic model_stall();
    return m.valid && m.is_load && (m.rd != 5'd0) && bus.i_id_valid &&
           ((m.rd == bus.i_id_rs1_addr) || (m.rd == bus.i_id_rs2_addr)) &&
           !bus.i_flush;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (!m.valid) return 2'b00;
    if (bus.i_exmem_rd_wren && bus.i_exmem_rd_addr != 5'd0 && bus.i_exmem_rd_addr == rs)
      return 2'b01;
    if (bus.i_memwb_rd_wren && bus.i_memwb_rd_addr != 5'd0 && bus.i_memwb_rd_addr == rs)
      return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wren, input logic ld);
    bus.i_id_valid    = v;
    bus.i_id_rs1_addr = rs1;
    bus.i_id_rs2_addr = rs2;
    bus.i_id_rd_addr  = rd;
    bus.i_id_rd_wren  = wren;
    bus.i_id_is_load  = ld;
    bus.i_id_rs1_data = $urandom;
    bus.i_id_rs2_data = $urandom;
    bus.i_id_imm      = $urandom;
    bus.i_id_pc       = $urandom;
  endtask

  task automatic set_wb(input logic ew, input logic [4:0] ea,
                        input logic mw, input logic [4:0] ma);
    bus.i_exmem_rd_wren = ew;
    bus.i_exmem_rd_addr = ea;
    bus.i_memwb_rd_wren = mw;
    bus.i_memwb_rd_addr = ma;
  endtask

  // Predict the next EX contents, push, advance one edge.
  task automatic tick();
    ex_t n;
    if (i_reset || bus.i_flush || model_stall()) begin
      n = '0;
    end else begin
      n.valid    = bus.i_id_valid;
      n.rd_wren  = bus.i_id_valid & bus.i_id_rd_wren;
      n.is_load  = bus.i_id_valid & bus.i_id_is_load;
      n.rs1      = bus.i_id_rs1_addr;
      n.rs2      = bus.i_id_rs2_addr;
      n.rd       = bus.i_id_rd_addr;
      n.rs1_data = bus.i_id_rs1_data;
      n.rs2_data = bus.i_id_rs2_data;
      n.imm      = bus.i_id_imm;
      n.pc       = bus.i_id_pc;
    end
    exp_q.push_back(n);
    @(posedge i_clk);
    #1;
    m = n;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    bus.i_flush = 1'b0;
    set_id(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1);
    set_wb(1'b1, 5'd4, 1'b1, 5'd5);
    tick();
    tick();
    exp = exp_q.pop_front();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp || got !== ex_t'(0)) begin
      bad++;
      $display("FAIL reset_regs got=%h exp=%h", got, exp);
    end
    total++;
    if (bus.o_stall !== 1'b0 || bus.o_fwd_a_sel !== 2'b00 || bus.o_fwd_b_sel !== 2'b00) begin
      bad++;
      $display("FAIL reset_ctrl got stall=%b a=%b b=%b exp 0/00/00",
               bus.o_stall, bus.o_fwd_a_sel, bus.o_fwd_b_sel);
    end
    i_reset = 1'b0;
  endtask

  task automatic test_normal();
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL normal_capture got=%h exp=%h", got, exp);
    end
    total++;
    if (bus.o_ex_rd_addr !== 5'd3 || bus.o_ex_valid !== 1'b1 ||
        bus.o_fwd_a_sel !== 2'b00 || bus.o_fwd_b_sel !== 2'b00) begin
      bad++;
      $display("FAIL normal_add got rd=%0d v=%b a=%b b=%b exp rd=3 v=1 a=00 b=00",
               bus.o_ex_rd_addr, bus.o_ex_valid, bus.o_fwd_a_sel, bus.o_fwd_b_sel);
    end
    // Invalid ID instruction: control bits must be gated off.
    set_id(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp || bus.o_ex_rd_wren !== 1'b0 || bus.o_ex_is_load !== 1'b0) begin
      bad++;
      $display("FAIL invalid_gating got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_forward();
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
    set_id(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 1'b0);
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL fwd_capture got=%h exp=%h", got, exp);
    end
    set_id(1'b1, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0);
    set_wb(1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    total++;
    if (bus.o_fwd_a_sel !== 2'b01 || bus.o_fwd_b_sel !== 2'b00) begin
      bad++;
      $display("FAIL fwd_exmem_wins got a=%b b=%b exp a=01 b=00",
               bus.o_fwd_a_sel, bus.o_fwd_b_sel);
    end
    set_wb(1'b0, 5'd5, 1'b1, 5'd5);
    #1;
    total++;
    if (bus.o_fwd_a_sel !== 2'b10) begin
      bad++;
      $display("FAIL fwd_memwb got a=%b exp a=10", bus.o_fwd_a_sel);
    end
    set_wb(1'b1, 5'd6, 1'b1, 5'd5);
    #1;
    total++;
    if (bus.o_fwd_a_sel !== 2'b10 || bus.o_fwd_b_sel !== 2'b01) begin
      bad++;
      $display("FAIL fwd_both got a=%b b=%b exp a=10 b=01",
               bus.o_fwd_a_sel, bus.o_fwd_b_sel);
    end
    // Bubble in EX: selects must stay 00 even if addresses match.
    set_id(1'b0, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0);
    tick();
    exp = exp_q.pop_front();
    set_wb(1'b1, 5'd5, 1'b1, 5'd6);
    #1;
    total++;
    if (bus.o_fwd_a_sel !== 2'b00 || bus.o_fwd_b_sel !== 2'b00) begin
      bad++;
      $display("FAIL fwd_invalid_ex got a=%b b=%b exp 00/00",
               bus.o_fwd_a_sel, bus.o_fwd_b_sel);
    end
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd2, 5'd3, 5'd7, 1'b1, 1'b1);
    tick();
    exp = exp_q.pop_front();
    set_id(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0);
    #1;
    total++;
    if (bus.o_stall !== 1'b1) begin
      bad++;
      $display("FAIL load_use_stall got=%b exp=1", bus.o_stall);
    end
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp || bus.o_ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL load_use_bubble got=%h exp=%h", got, exp);
    end
    total++;
    if (bus.o_stall !== 1'b0) begin
      bad++;
      $display("FAIL load_use_release got=%b exp=0", bus.o_stall);
    end
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp || bus.o_ex_rd_addr !== 5'd8 || bus.o_ex_valid !== 1'b1) begin
      bad++;
      $display("FAIL load_use_recapture got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_load_x0();
    set_id(1'b1, 5'd2, 5'd3, 5'd0, 1'b1, 1'b1);
    tick();
    exp = exp_q.pop_front();
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    #1;
    total++;
    if (bus.o_stall !== 1'b0) begin
      bad++;
      $display("FAIL load_x0_stall got=%b exp=0", bus.o_stall);
    end
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp || bus.o_ex_valid !== 1'b1) begin
      bad++;
      $display("FAIL load_x0_capture got=%h exp=%h", got, exp);
    end
    set_wb(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    total++;
    if (bus.o_fwd_a_sel !== 2'b00 || bus.o_fwd_b_sel !== 2'b00) begin
      bad++;
      $display("FAIL fwd_x0 got a=%b b=%b exp 00/00", bus.o_fwd_a_sel, bus.o_fwd_b_sel);
    end
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd2, 5'd3, 5'd7, 1'b1, 1'b1);
    tick();
    exp = exp_q.pop_front();
    set_id(1'b1, 5'd7, 5'd1, 5'd9, 1'b1, 1'b0);
    bus.i_flush = 1'b1;
    #1;
    total++;
    if (bus.o_stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall got=%b exp=0", bus.o_stall);
    end
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp || bus.o_ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_bubble got=%h exp=%h", got, exp);
    end
    bus.i_flush = 1'b0;
  endtask

  task automatic test_reset_override();
    set_id(1'b1, 5'd2, 5'd3, 5'd7, 1'b1, 1'b1);
    tick();
    exp = exp_q.pop_front();
    set_id(1'b1, 5'd7, 5'd7, 5'd9, 1'b1, 1'b0);
    bus.i_flush = 1'b1;
    i_reset = 1'b1;
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp || got !== ex_t'(0) || bus.o_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_flush got=%h stall=%b exp=%h stall=0", got, bus.o_stall, exp);
    end
    i_reset = 1'b0;
    bus.i_flush = 1'b0;
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp || bus.o_ex_valid !== 1'b1 || bus.o_ex_rd_addr !== 5'd9) begin
      bad++;
      $display("FAIL reset_release_capture got=%h exp=%h", got, exp);
    end
    // Reset during an active load-use: pending bubble discarded.
    set_id(1'b1, 5'd2, 5'd3, 5'd7, 1'b1, 1'b1);
    tick();
    exp = exp_q.pop_front();
    set_id(1'b1, 5'd7, 5'd1, 5'd10, 1'b1, 1'b0);
    i_reset = 1'b1;
    tick();
    exp = exp_q.pop_front();
    i_reset = 1'b0;
    tick();
    exp = exp_q.pop_front();
    got = dut_ex();
    total++;
    if (got !== exp || bus.o_ex_rd_addr !== 5'd10 || bus.o_ex_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_stall got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ea;
    logic [1:0] eb;
    for (int i = 0; i < 300; i++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2) == 0);
      set_wb(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
      bus.i_flush = ($urandom_range(0, 7) == 0);
      i_reset     = ($urandom_range(0, 31) == 0);
      #1;
      ea = model_fwd(m.rs1);
      eb = model_fwd(m.rs2);
      total++;
      if (bus.o_stall !== model_stall() || bus.o_fwd_a_sel !== ea || bus.o_fwd_b_sel !== eb) begin
        bad++;
        $display("FAIL b2b_ctrl[%0d] got stall=%b a=%b b=%b exp stall=%b a=%b b=%b",
                 i, bus.o_stall, bus.o_fwd_a_sel, bus.o_fwd_b_sel, model_stall(), ea, eb);
      end
      tick();
      exp = exp_q.pop_front();
      got = dut_ex();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b_regs[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    i_reset = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  initial begin
    m = '0;
    i_reset = 1'b1;
    bus.i_flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge i_clk);
    test_reset();
    test_normal();
    test_forward();
    test_load_use();
    test_load_x0();
    test_flush();
    test_reset_override();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
